snake_step_gen: RTL and testbench

Timing and control stage directly upstream of the two-digit seven-segment snake animation decoder. Divides the system clock into a programmable step rate and produces the 4-bit animation step index (0..11) that the decoder maps to segment patterns. Handles debounced speed-up, slow-down and pause buttons, plus a direction switch, so the snake can be slowed, stopped or reversed on the board.

---
 rtl/snake_pkg.sv | 7 +
 rtl/btn_debounce.sv | 36 +++
 rtl/snake_step_gen.sv | 66 ++++++
 tb/tb_snake_step_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: step/speed types and constants shared by the snake step generator and decoder
package snake_pkg;
    localparam int NUM_STEPS = 12;
    localparam int MAX_SPEED = 7;
    typedef logic [3:0] step_t;
    typedef logic [2:0] speed_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debouncer and one-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic level;
    logic [CW-1:0] cnt;
    logic done;
    assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
    // the press pulse is registered on the same edge that accepts the new level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            level <= 1'b0;
            cnt <= '0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            press <= sync[1] & ~level & done;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (done) begin
                level <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/snake_step_gen.sv
// snake_step_gen: programmable-rate animation step counter with speed, pause and direction controls
module snake_step_gen
    import snake_pkg::*;
#(
    parameter int BASE_DIV = 2_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   btn_faster,
    input  logic   btn_slower,
    input  logic   btn_pause,
    input  logic   dir,
    output step_t  step,
    output logic   step_valid,
    output speed_t speed,
    output logic   paused
);
    localparam int DW = $clog2(BASE_DIV);
    logic faster, slower, pause_ev, run, term;
    logic [1:0] dir_sync;
    logic [DW-1:0] cnt, last;
    speed_t speed_nxt;
    step_t step_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
        .clock(clock), .reset(reset), .btn(btn_faster), .press(faster));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
        .clock(clock), .reset(reset), .btn(btn_slower), .press(slower));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clock(clock), .reset(reset), .btn(btn_pause), .press(pause_ev));

    assign speed_nxt = (faster && !slower && speed != speed_t'(MAX_SPEED)) ? speed + 3'd1 :
                       (slower && !faster && speed != '0) ? speed - 3'd1 : speed;
    assign last = DW'((BASE_DIV >> speed) - 1);
    assign term = cnt == last;
    // a pause event wins over a coinciding terminal count, so the count holds
    assign run = !paused && !pause_ev;
    assign step_nxt = dir_sync[1] ? (step == '0 ? step_t'(NUM_STEPS - 1) : step - 4'd1) :
                      (step == step_t'(NUM_STEPS - 1) ? '0 : step + 4'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_sync <= '0;
            speed <= '0;
            paused <= 1'b0;
            cnt <= '0;
            step <= '0;
            step_valid <= 1'b0;
        end else begin
            dir_sync <= {dir_sync[0], dir};
            speed <= speed_nxt;
            paused <= paused ^ pause_ev;
            step_valid <= 1'b0;
            if (speed_nxt != speed) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= term ? '0 : cnt + DW'(1);
                if (term) begin
                    step <= step_nxt;
                    step_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_snake_step_gen.sv
// tb_snake_step_gen: randomized and directed scoreboard bench against a rule-level reference model
module tb_snake_step_gen;
    import snake_pkg::*;
    localparam int BD = 256;
    localparam int DC = 4;
    logic clock = 0, reset = 1, btn_faster = 0, btn_slower = 0, btn_pause = 0, dir = 0;
    step_t step;
    logic step_valid;
    speed_t speed;
    logic paused;
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    snake_step_gen #(.BASE_DIV(BD), .DEBOUNCE_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .btn_faster(btn_faster), .btn_slower(btn_slower),
        .btn_pause(btn_pause), .dir(dir), .step(step), .step_valid(step_valid),
        .speed(speed), .paused(paused));

    int m_speed, m_paused, m_step, m_phase;
    int run_len [3];
    bit lvl [3];
    bit ev [3];
    bit h1 [4];
    bit h2 [4];
    int exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // reference: inputs act two samples late, a level is accepted after DC differing samples,
    // and an accepted press reaches speed/paused on the following edge
    always @(posedge clock) begin
        bit raw [4];
        int ns;
        raw = '{btn_faster, btn_slower, btn_pause, dir};
        if (reset) begin
            m_speed = 0; m_paused = 0; m_step = 0; m_phase = 0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin h1[i] = 0; h2[i] = 0; end
            for (int i = 0; i < 3; i++) begin run_len[i] = 0; lvl[i] = 0; ev[i] = 0; end
        end else begin
            ns = m_speed + ((ev[0] && !ev[1]) ? 1 : 0) - ((ev[1] && !ev[0]) ? 1 : 0);
            if (ns > MAX_SPEED) ns = MAX_SPEED;
            if (ns < 0) ns = 0;
            if (ns != m_speed) begin
                m_speed = ns;
                m_phase = 0;
            end else if (!m_paused && !ev[2]) begin
                if (m_phase == (BD >> m_speed) - 1) begin
                    m_phase = 0;
                    m_step = h2[3] ? (m_step + NUM_STEPS - 1) % NUM_STEPS : (m_step + 1) % NUM_STEPS;
                    exp_q.push_back(m_step);
                end else m_phase++;
            end
            if (ev[2]) m_paused = 1 - m_paused;
            for (int i = 0; i < 3; i++) begin
                ev[i] = 0;
                if (h2[i] == lvl[i]) run_len[i] = 0;
                else begin
                    run_len[i]++;
                    if (run_len[i] == DC) begin
                        lvl[i] = h2[i];
                        run_len[i] = 0;
                        ev[i] = h2[i];
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin h2[i] = h1[i]; h1[i] = raw[i]; end
        end
    end

    always @(negedge clock) begin
        chk("speed", speed, m_speed);
        chk("paused", paused, m_paused);
        chk("step", step, m_step);
        chk("step_valid", step_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            int e;
            e = exp_q.pop_front();
            if (step_valid) chk("sb_step", step, e);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0) btn_faster = v;
        else if (b == 1) btn_slower = v;
        else btn_pause = v;
    endtask

    task automatic press(input int b, input int hold, input int rel);
        set_btn(b, 1'b1);
        cycles(hold);
        set_btn(b, 1'b0);
        cycles(rel);
    endtask

    task automatic presses(input int b, input int k);
        repeat (k) press(b, 10, 10);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!step_valid && n < limit);
        chk("step_valid_timeout", step_valid, 1);
    endtask

    initial begin
        int n, s, k;
        cycles(3);
        chk("rst_step", step, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_speed", speed, 0);
        chk("rst_paused", paused, 0);
        reset = 0;
        n = 0;
        while (!step_valid && n < 1000) begin
            cycles(1);
            n++;
        end
        chk("first_step_latency", n, BD);
        repeat (11) wait_valid(BD + 10, n);
        chk("period_speed0", n, BD);
        chk("forward_wrap", step, 0);

        presses(0, 3);
        chk("speed_after_3_faster", speed, 3);
        wait_valid(100, n);
        wait_valid(100, n);
        chk("period_speed3", n, 32);
        presses(0, 5);
        chk("speed_saturates", speed, 7);
        wait_valid(10, n);
        wait_valid(10, n);
        chk("period_speed7", n, 2);
        presses(1, 9);
        chk("speed_floor", speed, 0);

        for (int i = 0; i < 10; i++) begin
            btn_pause = ~btn_pause;
            cycles(2);
        end
        press(2, 10, 10);
        chk("bounce_single_toggle", paused, 1);
        k = 0;
        repeat (500) begin
            cycles(1);
            k += int'(step_valid);
        end
        chk("no_step_while_paused", k, 0);
        press(2, 10, 10);
        chk("unpaused", paused, 0);

        presses(0, 3);
        k = 0;
        do begin
            wait_valid(40, n);
            k++;
        end while (step != 0 && k < 14);
        chk("reached_step0", step, 0);
        dir = 1;
        wait_valid(40, n);
        chk("reverse_wrap", step, 11);
        wait_valid(40, n);
        chk("reverse_step", step, 10);
        cycles(10);
        dir = 0;
        wait_valid(40, n);
        chk("forward_again", step, 11);

        btn_faster = 1;
        btn_slower = 1;
        cycles(10);
        btn_faster = 0;
        btn_slower = 0;
        cycles(10);
        chk("simultaneous_speed", speed, 3);

        n = 0;
        while (!(m_phase == 32 - 7 && m_paused == 0) && n < 200) begin
            cycles(1);
            n++;
        end
        chk("align_timeout", int'(n < 200), 1);
        s = step;
        press(2, 10, 10);
        chk("pause_on_terminal", paused, 1);
        chk("pause_on_terminal_step", step, s);
        press(2, 10, 10);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 4);
            if (k == 4) dir = ~dir;
            else if (k == 3) begin
                for (int j = 0; j < 6; j++) begin
                    btn_slower = ~btn_slower;
                    cycles($urandom_range(1, 3));
                end
                btn_slower = 0;
            end else press(k, $urandom_range(1, 12), $urandom_range(1, 12));
            cycles($urandom_range(1, 60));
        end

        dir = 0;
        presses(1, 8);
        if (m_paused != 0) press(2, 10, 10);
        k = 0;
        do begin
            wait_valid(BD + 10, n);
            k++;
        end while (step != 7 && k < 14);
        press(2, 10, 10);
        presses(0, 5);
        chk("pre_reset_speed", speed, 5);
        chk("pre_reset_step", step, 7);
        chk("pre_reset_paused", paused, 1);
        reset = 1;
        cycles(1);
        reset = 0;
        chk("midrun_reset_step", step, 0);
        chk("midrun_reset_valid", step_valid, 0);
        chk("midrun_reset_speed", speed, 0);
        chk("midrun_reset_paused", paused, 0);
        cycles(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
